coin_acceptor: RTL and testbench

- Upstream stage of the vending FSM; produces the 2-bit coin code X that the FSM consumes.
- Synchronises and debounces two raw coin-sensor lines (nickel, dime).
- Turns each debounced rising edge into exactly one single-cycle coin code.
- Holds pending coins while the FSM is vending (prim_output high), so no coin is dropped during the s15 cycle.

---
 rtl/coin_pkg.sv | 19 +
 rtl/coin_debounce.sv | 50 +++++
 rtl/coin_acceptor.sv | 103 ++++++++++
 tb/tb_coin_acceptor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes and issue-FSM state encodings for the coin acceptor.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'b00,
    COIN_NICKEL = 2'b01,
    COIN_DIME   = 2'b10
  } coin_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    GAP   = 2'b10
  } issue_state_e;

  localparam int CH_NICKEL = 0;
  localparam int CH_DIME   = 1;

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: two-flop synchroniser, run-length debounce counter and
// a one-cycle pulse on each debounced rising edge.
module coin_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic rise_o
);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_prev_q;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign rise_o = level_q & ~level_prev_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: per-channel pending flags, the IDLE/ISSUE/GAP issue FSM
// and the registered coin_code / coin_lost outputs feeding the vending FSM.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DB_CYCLES  = 4,
  parameter int DB_W       = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       hold,
  output logic [1:0] coin_code,
  output logic       coin_lost,
  output logic       busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [1:0]       rise;
  logic [1:0]       issue_clr;
  logic [1:0]       pend_q, pend_d;
  issue_state_e     state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  coin_e            code_q, code_d;
  logic             lost_q, lost_d;

  coin_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_nickel (
    .clock  (clock),
    .reset  (reset),
    .raw_i  (nickel_raw),
    .rise_o (rise[CH_NICKEL])
  );

  coin_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_dime (
    .clock  (clock),
    .reset  (reset),
    .raw_i  (dime_raw),
    .rise_o (rise[CH_DIME])
  );

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    code_d    = COIN_NONE;
    issue_clr = 2'b00;
    case (state_q)
      IDLE: begin
        if (!hold && (|pend_q)) begin
          state_d = ISSUE;
          // Dime wins when both channels are pending.
          if (pend_q[CH_DIME]) begin
            code_d             = COIN_DIME;
            issue_clr[CH_DIME] = 1'b1;
          end else begin
            code_d               = COIN_NICKEL;
            issue_clr[CH_NICKEL] = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (GAP_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A new edge always sets the flag, even when the same channel is being issued.
    pend_d = rise | (pend_q & ~issue_clr);
    lost_d = |(rise & pend_q & ~issue_clr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      pend_q  <= 2'b00;
      code_q  <= COIN_NONE;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      lost_q  <= lost_d;
    end
  end

  assign coin_code = code_q;
  assign coin_lost = lost_q;
  assign busy      = (state_q != IDLE) || (|pend_q);

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random sensor
// activity, all compared cycle by cycle against a behavioural reference model.
module tb_coin_acceptor;

  localparam int DB  = 4;
  localparam int GAP = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       nickel_raw = 1'b0;
  logic       dime_raw = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] coin_code;
  logic       coin_lost;
  logic       busy;

  always #5 clock = ~clock;

  coin_acceptor #(.DB_CYCLES(DB), .DB_W(3), .GAP_CYCLES(GAP)) dut (
    .clock      (clock),
    .reset      (reset),
    .nickel_raw (nickel_raw),
    .dime_raw   (dime_raw),
    .hold       (hold),
    .coin_code  (coin_code),
    .coin_lost  (coin_lost),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
  endtask

  // Reference model: sensor samples reach the debouncer two edges late; a level
  // flips once DB consecutive samples disagree with it; issues are spaced by a
  // "next allowed edge" number rather than by explicit states.
  bit m_s1[2], m_s2[2], m_lvl[2], m_rise[2], m_pend[2];
  int m_run[2];
  int m_next_ok;
  int m_code;
  bit m_lost, m_busy;

  task automatic model_step(input bit r, input bit n, input bit d, input bit h);
    bit raw[2];
    bit clr[2];
    bit np[2];
    int t;
    raw[0] = n;
    raw[1] = d;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_rise[c] = 0; m_pend[c] = 0; m_run[c] = 0;
      end
      m_next_ok = 0;
      m_code    = 0;
      m_lost    = 0;
      m_busy    = 0;
      return;
    end
    t      = edge_n;
    m_code = 0;
    clr[0] = 0;
    clr[1] = 0;
    if (t >= m_next_ok && !h && (m_pend[0] || m_pend[1])) begin
      if (m_pend[1]) begin clr[1] = 1; m_code = 2; end
      else           begin clr[0] = 1; m_code = 1; end
      m_next_ok = t + GAP + 2;
    end
    m_lost = 0;
    for (int c = 0; c < 2; c++) begin
      bit new_rise;
      if (m_rise[c] && m_pend[c] && !clr[c]) m_lost = 1;
      np[c]    = m_rise[c] || (m_pend[c] && !clr[c]);
      new_rise = 0;
      if (m_s2[c] != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_lvl[c] = !m_lvl[c];
          m_run[c] = 0;
          new_rise = m_lvl[c];
        end
      end else begin
        m_run[c] = 0;
      end
      m_rise[c] = new_rise;
      m_s2[c]   = m_s1[c];
      m_s1[c]   = raw[c];
      m_pend[c] = np[c];
    end
    m_busy = (t + 1 < m_next_ok) || np[0] || np[1];
  endtask

  // Drive at the falling edge, let one rising edge happen, compare 1 ns later.
  task automatic tick(input bit r, input bit n, input bit d, input bit h);
    reset      = r;
    nickel_raw = n;
    dime_raw   = d;
    hold       = h;
    model_step(r, n, d, h);
    @(posedge clock);
    #1;
    check("coin_code", {30'b0, coin_code}, m_code);
    check("coin_lost", {31'b0, coin_lost}, m_lost);
    check("busy",      {31'b0, busy},      m_busy);
    edge_n++;
    @(negedge clock);
  endtask

  int n_nick, n_dime, n_lost, first_nick, first_dime, first_lost;

  task automatic clear_obs();
    n_nick = 0; n_dime = 0; n_lost = 0;
    first_nick = -1; first_dime = -1; first_lost = -1;
  endtask

  task automatic observe(input int i);
    if (coin_code == 2'b01) begin if (n_nick == 0) first_nick = i; n_nick++; end
    if (coin_code == 2'b10) begin if (n_dime == 0) first_dime = i; n_dime++; end
    if (coin_lost)          begin if (n_lost == 0) first_lost = i; n_lost++; end
  endtask

  initial begin
    @(negedge clock);

    // Reset state
    clear_obs();
    tick(1, 0, 0, 0);
    check("rst_code", {30'b0, coin_code}, 0);
    check("rst_lost", {31'b0, coin_lost}, 0);
    check("rst_busy", {31'b0, busy}, 0);

    // Nickel clean
    for (int i = 1; i <= 45; i++) begin tick(0, i >= 10 && i < 30, 0, 0); observe(i); end
    check("nickel_count", n_nick, 1);
    check("nickel_edge", first_nick, 17);
    check("nickel_lost", n_lost, 0);

    // Bounce on dime, settling high at edge 22
    clear_obs();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 50; i++) begin
      bit d;
      d = (i >= 22) || (i >= 10 && (((i - 10) / 2) % 2 == 0));
      tick(0, 0, d, 0);
      observe(i);
    end
    check("bounce_count", n_dime, 1);
    check("bounce_edge", first_dime, 29);
    check("bounce_nick", n_nick, 0);

    // Simultaneous rise
    clear_obs();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 40; i++) begin tick(0, i >= 10, i >= 10, 0); observe(i); end
    check("simul_dime_edge", first_dime, 17);
    check("simul_nick_edge", first_nick, 21);
    check("simul_counts", n_nick + n_dime, 2);
    check("simul_lost", n_lost, 0);

    // Hold blocks issue
    clear_obs();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      tick(0, i >= 10 && i < 30, 0, i <= 21);
      observe(i);
      if (i == 21) begin
        check("hold_busy", {31'b0, busy}, 1);
        check("hold_code", {30'b0, coin_code}, 0);
      end
    end
    check("hold_edge", first_nick, 22);
    check("hold_count", n_nick, 1);

    // Overflow: second nickel while the first is still pending
    clear_obs();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 60; i++) begin
      tick(0, (i >= 10 && i < 18) || (i >= 26 && i < 34), 0, i <= 45);
      observe(i);
    end
    check("ovf_lost_count", n_lost, 1);
    check("ovf_lost_edge", first_lost, 32);
    check("ovf_nick_count", n_nick, 1);
    check("ovf_nick_edge", first_nick, 46);

    // Reset mid-GAP with a dime pending
    clear_obs();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      tick(i == 19, i >= 10 && i < 16, i >= 12 && i < 18, 0);
      observe(i);
      if (i == 18) check("gap_busy", {31'b0, busy}, 1);
      if (i == 19) begin
        check("rstgap_code", {30'b0, coin_code}, 0);
        check("rstgap_busy", {31'b0, busy}, 0);
      end
    end
    check("rstgap_nick_edge", first_nick, 17);
    check("rstgap_dime", n_dime, 0);

    // Random sensor activity, hold and occasional reset
    begin
      bit lvl[2];
      int dur[2];
      bit h;
      int h_dur;
      lvl[0] = 0; lvl[1] = 0; dur[0] = 0; dur[1] = 0; h = 0; h_dur = 0;
      tick(1, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
        for (int c = 0; c < 2; c++) begin
          if (dur[c] == 0) begin
            lvl[c] = 1'($urandom_range(0, 1));
            dur[c] = int'($urandom_range(1, 12));
          end
          dur[c]--;
        end
        if (h_dur == 0) begin
          h     = ($urandom_range(0, 9) < 3);
          h_dur = int'($urandom_range(1, 10));
        end
        h_dur--;
        tick($urandom_range(0, 599) == 0, lvl[0], lvl[1], h);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
